// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared tap table and FSM state type for the LFSR random source
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        VALID
    } rand_state_e;

    // Maximal-length feedback taps, bit i set means state[i] feeds the XOR.
    function automatic logic [15:0] lfsr_taps(input int width);
        case (width)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR register with seed load and lock-up guard
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int          OUT_W = 5,
    parameter int unsigned SEED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic [OUT_W-1:0] cand
);

    localparam logic [WIDTH-1:0] TAPS   = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_V = WIDTH'(SEED);

    logic             fb;
    logic [WIDTH-1:0] state_next;

    assign fb         = ^(state & TAPS);
    // A zero state is replaced by SEED instead of stepping, so the candidate
    // seen by the FSM always matches what the register will actually hold.
    assign state_next = (state == '0) ? SEED_V : {state[WIDTH-2:0], fb};
    assign cand       = state_next[OUT_W-1:0];

    // Load beats lock-up recovery, which beats a normal step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED_V;
        end else if (load) begin
            state <= (load_val == '0) ? SEED_V : load_val;
        end else if (state == '0) begin
            state <= SEED_V;
        end else if (step) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/lfsr_rand_gen.sv
// rtl/lfsr_rand_gen.sv - range-limited LFSR random source; RAND_REJECT_CNT_EN adds reject_cnt
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          OUT_W     = 5,
    parameter int          RANGE_MAX = 20,
    parameter int unsigned SEED      = 1,
    parameter int          MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             rand_valid,
    input  logic             rand_ready,
    output logic [OUT_W-1:0] rand_out,
    output logic [WIDTH-1:0] lfsr_state
`ifdef RAND_REJECT_CNT_EN
    ,
    output logic [15:0]      reject_cnt
`endif
);

    localparam int TRY_W = (MAX_TRIES < 2) ? 1 : $clog2(MAX_TRIES);

    rand_state_e      fsm;
    logic [TRY_W-1:0] tries;
    logic [OUT_W-1:0] cand;
    logic             in_range;
    logic             step;

    assign in_range = (cand <= OUT_W'(RANGE_MAX));
    // In IDLE a pending request wins over free-running stepping.
    assign step     = (fsm == SEARCH) || ((fsm == IDLE) && step_en && !req_valid);

    lfsr_core #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (lfsr_state),
        .cand     (cand)
    );

    // Request/search/hold sequencing; seed_load aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            rand_out   <= '0;
            rand_valid <= 1'b0;
            req_ready  <= 1'b1;
            tries      <= '0;
        end else if (seed_load) begin
            fsm        <= IDLE;
            rand_valid <= 1'b0;
            req_ready  <= 1'b1;
            tries      <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (req_valid) begin
                        fsm       <= SEARCH;
                        req_ready <= 1'b0;
                        tries     <= '0;
                    end
                end
                SEARCH: begin
                    if (in_range) begin
                        rand_out   <= cand;
                        rand_valid <= 1'b1;
                        fsm        <= VALID;
                    end else if (tries == TRY_W'(MAX_TRIES - 1)) begin
                        // Out of attempts: fold the oversize value back into range.
                        rand_out   <= cand - OUT_W'(RANGE_MAX + 1);
                        rand_valid <= 1'b1;
                        fsm        <= VALID;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                VALID: begin
                    if (rand_ready) begin
                        fsm        <= IDLE;
                        rand_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef RAND_REJECT_CNT_EN
    logic reject;

    assign reject = (fsm == SEARCH) && !seed_load && !in_range;

    // Saturating count of rejected candidates; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reject_cnt <= '0;
        end else if (reject && (reject_cnt != 16'hFFFF)) begin
            reject_cnt <= reject_cnt + 16'd1;
        end
    end
`endif

endmodule
